// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, AXIS or FIFO byte output.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling.
module uart_rx #(
    parameter int    clk_frequency = 200000000,
    parameter int    baud_rate     = 115200,
    parameter string interface_sel = "axis"
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte_data,
    output logic       rx_byte_valid,
    input  logic       rx_byte_ready,
    output logic [7:0] rx_fifo_din,
    output logic       rx_fifo_wen,
    input  logic       rx_fifo_full,
    output logic       rx_idle,
    output logic       rx_done,
    output logic       rx_frame_err,
    output logic       rx_overflow
);

    localparam int div_n  = clk_frequency / baud_rate;
    localparam int half_n = div_n / 2;
    localparam int cnt_w  = $clog2(div_n);
    localparam logic [cnt_w-1:0] div_last  = cnt_w'(div_n - 1);
    localparam logic [cnt_w-1:0] half_last = cnt_w'(half_n - 1);
    localparam bit is_fifo = (interface_sel == "fifo");

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [cnt_w-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       data;
    logic             valid;
    logic             wen;
    logic             rx_meta;
    logic             rx_s;
    logic             rx_d;
    logic             sample;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // rx_d, rx_s and rx_meta are rx_s at the nominal cycle -1, 0 and +1
    assign sample = (rx_d & rx_s) | (rx_d & rx_meta) | (rx_s & rx_meta);
`else
    assign sample = rx_s;
`endif

    assign rx_byte_data  = data;
    assign rx_fifo_din   = data;
    assign rx_byte_valid = valid;
    assign rx_fifo_wen   = wen;
    assign rx_idle       = (state == IDLE) && rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            data         <= '0;
            valid        <= 1'b0;
            wen          <= 1'b0;
            rx_done      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overflow  <= 1'b0;
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            rx_d         <= 1'b1;
        end else begin
            rx_meta      <= rx;
            rx_s         <= rx_meta;
            rx_d         <= rx_s;
            wen          <= 1'b0;
            rx_done      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overflow  <= 1'b0;
            if (valid && rx_byte_ready)
                valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == half_last) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sample ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + cnt_w'(1);
                    end
                end
                DATA: begin
                    if (cnt == div_last) begin
                        cnt     <= '0;
                        shift   <= {sample, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + cnt_w'(1);
                    end
                end
                STOP: begin
                    if (cnt == div_last) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!sample) begin
                            rx_frame_err <= 1'b1;
                        end else if (is_fifo) begin
                            if (rx_fifo_full) begin
                                rx_overflow <= 1'b1;
                            end else begin
                                data    <= shift;
                                wen     <= 1'b1;
                                rx_done <= 1'b1;
                            end
                        end else if (valid && !rx_byte_ready) begin
                            // keep the unconsumed byte, drop the new one
                            rx_overflow <= 1'b1;
                        end else begin
                            data    <= shift;
                            valid   <= 1'b1;
                            rx_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + cnt_w'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter clk_frequency, default 200000000, clock frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 115200, line bit rate.
REQ-003 SHALL have parameter interface, default "axis", output protocol ("axis"|"fifo").
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port rx  input  1  asynchronous UART serial line, idle high.
REQ-007 SHALL have ports rx_byte_data  output  8, rx_byte_valid  output  1 and rx_byte_ready  input  1, forming the AXIS master byte stream.
REQ-008 SHALL have ports rx_fifo_din  output  8, rx_fifo_wen  output  1 and rx_fifo_full  input  1, forming the FIFO write port.
REQ-009 SHALL have ports rx_idle  output  1 (receiver idle), rx_done  output  1 (byte accepted pulse), rx_frame_err  output  1 (stop-bit error pulse) and rx_overflow  output  1 (byte dropped pulse).

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer whose flops reset to 1; all decisions SHALL use the synchronized value rx_s.
REQ-011 SHALL use div_n = clk_frequency/baud_rate (integer) and half_n = div_n/2; div_n < 8 is unsupported.
REQ-012 SHALL implement the states IDLE, START, DATA and STOP.
REQ-013 IDLE SHALL detect a 1->0 transition of rx_s, clear the baud counter, and enter START on the same edge.
REQ-014 START SHALL sample at counter value half_n-1; sample=0 -> clear the counter and enter DATA; sample=1 -> return to IDLE as a glitch, with no output and no error.
REQ-015 DATA SHALL take one sample every div_n cycles (counter wraps at div_n-1), shift LSB first, and enter STOP after the 8th sample.
REQ-016 STOP SHALL sample after div_n cycles; sample=1 -> deliver the byte; sample=0 -> discard the byte, pulse rx_frame_err for 1 cycle. Either way SHALL return to IDLE on the next cycle, mid-stop-bit, ready for the next start edge.
REQ-017 In axis mode, a delivered byte SHALL load rx_byte_data and assert rx_byte_valid one cycle after the stop sample.
REQ-018 rx_byte_valid SHALL hold, with stable data, until a cycle with rx_byte_ready=1; valid SHALL drop the next cycle unless a new byte loads the same cycle.
REQ-019 In axis mode, delivering a byte while rx_byte_valid=1 and rx_byte_ready=0 SHALL drop the new byte, keep the old data, and pulse rx_overflow for 1 cycle.
REQ-020 In fifo mode, a delivered byte SHALL drive rx_fifo_din and pulse rx_fifo_wen for 1 cycle, one cycle after the stop sample, if rx_fifo_full=0; otherwise no write and rx_overflow SHALL pulse for 1 cycle.
REQ-021 rx_done SHALL pulse for 1 cycle in the cycle the byte is accepted into the output register or FIFO; it SHALL NOT pulse for dropped or errored bytes.
REQ-022 rx_idle SHALL be 1 iff the state is IDLE and rx_s=1.
REQ-023 In axis mode, rx_fifo_wen SHALL be 0; in fifo mode, rx_byte_valid SHALL be 0.

Reset
REQ-024 On rst_n=0 at a clk edge, the block SHALL set state=IDLE, counter=0, shift register=0, rx_byte_data=0, rx_byte_valid=0, rx_fifo_wen=0, rx_done=0, rx_frame_err=0, rx_overflow=0, rx_idle=1 and the synchronizer flops to 1.
REQ-025 Reset mid-frame SHALL abandon the frame with no output pulse; reception SHALL resume at the next falling edge after release.

Configuration
REQ-026 With macro UART_RX_MAJORITY_VOTE_EN defined, each start, data and stop sample SHALL be the 2-of-3 majority of rx_s at the nominal sample cycle -1, 0 and +1; the decision SHALL stay on the nominal cycle.
REQ-027 Without UART_RX_MAJORITY_VOTE_EN, each sample SHALL be the single rx_s value at the nominal cycle.

Verification (clk_frequency=1000000, baud_rate=100000, div_n=10)
REQ-028 Frame 0x55 with valid stop bit and ready=0 -> rx_byte_valid=1, data=0x55 held until ready=1; rx_done pulses once.
REQ-029 3-cycle low glitch on idle rx -> no valid, no rx_frame_err, return to IDLE.
REQ-030 Frame 0xA3 with stop bit=0 -> rx_frame_err 1-cycle pulse, no valid, no rx_done.
REQ-031 Back-to-back 0x01 then 0x02 with ready=0 -> data stays 0x01, rx_overflow pulses once; fifo mode with full=1 -> no wen, rx_overflow pulses.
REQ-032 rst_n=0 during bit 4 of 0xFF, then frame 0x3C -> no output for 0xFF; 0x3C received correctly.
REQ-033 With UART_RX_MAJORITY_VOTE_EN, 1-cycle inversion at the nominal sample of bit 2 of 0x96 -> 0x96 received; without the macro, the same stimulus -> 0x92.
